rsa_msg_sequencer: RTL and testbench

RSA_MSG_SEQUENCER -- requirements
Module: rsa_msg_sequencer

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/rsa_watchdog.sv | 32 +++
 rtl/rsa_msg_sequencer.sv | 128 ++++++++++++
 tb/tb_rsa_msg_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA message sequencer: FSM encoding and
// watchdog sizing.
package rsa_pkg;

    localparam int TIMEOUT_DEFAULT = 255;
    localparam int WD_WIDTH        = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } seq_state_e;

    // The counter value seen in the last permitted WAIT cycle.
    function automatic logic [WD_WIDTH-1:0] wdLastCount(input int timeout);
        return WD_WIDTH'(timeout - 1);
    endfunction

endpackage

// File: rtl/rsa_watchdog.sv
// Engine-wait watchdog: counts enabled cycles and flags the final one
// before the TIMEOUT budget is exhausted.
module rsa_watchdog
    import rsa_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam logic [WD_WIDTH-1:0] LAST = wdLastCount(TIMEOUT);

    logic [WD_WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // Expiry fires in the TIMEOUT-th enabled cycle, so the wait lasts exactly TIMEOUT cycles.
    assign o_expire = i_enable & (r_count == LAST);

endmodule

// File: rtl/rsa_msg_sequencer.sv
// Feeds plaintext words one at a time to a modular-exponentiation engine,
// guards against degenerate operands and engine hangs, and streams results.
module rsa_msg_sequencer
    import rsa_pkg::*;
#(
    parameter int n       = 6,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_load,
    input  logic [n-1:0] key_in,
    input  logic [n-1:0] mod_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] in_data,
    output logic         eng_start,
    output logic [n-1:0] eng_base,
    output logic [n-1:0] eng_key,
    output logic [n-1:0] eng_n,
    input  logic [n-1:0] eng_result,
    input  logic         eng_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] out_data,
    output logic         out_err,
    output logic         busy
);

    seq_state_e   r_state;
    seq_state_e   w_nextState;
    logic         r_keyValid;
    logic [n-1:0] r_key;
    logic [n-1:0] r_mod;
    logic [n-1:0] r_base;
    logic [n-1:0] r_outData;
    logic         r_outErr;
    logic         w_accept;
    logic         w_badOperand;
    logic         w_wdExpire;

    assign in_ready  = (r_state == ST_IDLE) & r_keyValid & ~key_load;
    assign w_accept  = in_valid & in_ready;
    // A modulus below 2 or a base not reduced by it has no meaningful result.
    assign w_badOperand = (r_mod[n-1:1] == '0) | (in_data >= r_mod);

    assign eng_start = (r_state == ST_LAUNCH);
    assign eng_base  = r_base;
    assign eng_key   = r_key;
    assign eng_n     = r_mod;
    assign out_valid = (r_state == ST_HOLD);
    assign out_data  = r_outData;
    assign out_err   = r_outErr;
    assign busy      = (r_state != ST_IDLE);

    rsa_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clear  (r_state != ST_WAIT),
        .i_enable (r_state == ST_WAIT),
        .o_expire (w_wdExpire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_nextState = w_badOperand ? ST_HOLD : ST_LAUNCH;
                end
            end
            ST_LAUNCH: w_nextState = ST_WAIT;
            ST_WAIT: begin
                if (eng_done || w_wdExpire) begin
                    w_nextState = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // Key material only changes while idle, so the engine operands stay frozen mid-operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_keyValid <= 1'b0;
            r_key      <= '0;
            r_mod      <= '0;
            r_base     <= '0;
            r_outData  <= '0;
            r_outErr   <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) && key_load) begin
                r_keyValid <= 1'b1;
                r_key      <= key_in;
                r_mod      <= mod_in;
            end
            if (w_accept) begin
                r_base <= in_data;
            end
            if (w_accept && w_badOperand) begin
                r_outData <= '0;
                r_outErr  <= 1'b1;
            end else if ((r_state == ST_WAIT) && eng_done) begin
                r_outData <= eng_result;
                r_outErr  <= 1'b0;
            end else if ((r_state == ST_WAIT) && w_wdExpire) begin
                r_outData <= '0;
                r_outErr  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rsa_msg_sequencer.sv
// Self-checking bench for rsa_msg_sequencer: directed corner cases plus
// randomized transactions against a transaction-level reference model.
module tb_rsa_msg_sequencer;

    localparam int N   = 6;
    localparam int TMO = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_load;
    logic [N-1:0] key_in;
    logic [N-1:0] mod_in;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         eng_start;
    logic [N-1:0] eng_base;
    logic [N-1:0] eng_key;
    logic [N-1:0] eng_n;
    logic [N-1:0] eng_result;
    logic         eng_done;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_err;
    logic         busy;

    int compareCount  = 0;
    int mismatchCount = 0;
    int startCount    = 0;

    // Reference model state: the key pair the sequencer should currently hold.
    int mKey;
    int mMod;

    always #5 clk = ~clk;

    rsa_msg_sequencer #(
        .n       (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_load   (key_load),
        .key_in     (key_in),
        .mod_in     (mod_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .eng_start  (eng_start),
        .eng_base   (eng_base),
        .eng_key    (eng_key),
        .eng_n      (eng_n),
        .eng_result (eng_result),
        .eng_done   (eng_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err),
        .busy       (busy)
    );

    // Count engine launches, one per cycle in which eng_start is high.
    always @(negedge clk) begin
        if (eng_start === 1'b1) startCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    function automatic int modExp(input int b, input int e, input int m);
        int r;
        r = 1 % m;
        for (int i = 0; i < e; i++) r = (r * b) % m;
        return r;
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 0);
        checkOutput({tag, "_eng_start"}, 32'(eng_start), 0);
        checkOutput({tag, "_eng_base"}, 32'(eng_base), 0);
        checkOutput({tag, "_eng_key"}, 32'(eng_key), 0);
        checkOutput({tag, "_eng_n"}, 32'(eng_n), 0);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 0);
        checkOutput({tag, "_out_data"}, 32'(out_data), 0);
        checkOutput({tag, "_out_err"}, 32'(out_err), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;
    endtask

    task automatic loadKey(input int k, input int m);
        key_load = 1'b1;
        key_in   = N'(k);
        mod_in   = N'(m);
        #1;
        checkOutput("in_ready_on_keyload", 32'(in_ready), 0);
        @(negedge clk);
        key_load = 1'b0;
        key_in   = N'($urandom);
        mod_in   = N'($urandom);
        mKey     = k;
        mMod     = m;
    endtask

    // One whole transaction from idle through the output handshake.
    // doneDelay: WAIT cycle in which the engine answers (0 = never).
    task automatic applyStimulus(input int base, input int doneDelay, input int readyDelay,
                                 input bit keyLoadInWait, input bit doneInLaunch);
        bit bad;
        bit timedOut;
        int waitLen;
        int expData;
        int expErr;
        int startsBefore;
        int result;
        startsBefore = startCount;
        #1;
        checkOutput("in_ready_idle", 32'(in_ready), 1);
        checkOutput("busy_idle", 32'(busy), 0);
        in_valid = 1'b1;
        in_data  = N'(base);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = N'($urandom);
        bad = (mMod < 2) || (base >= mMod);
        timedOut = 1'b0;
        if (bad) begin
            expData = 0;
            expErr  = 1;
            checkOutput("err_eng_start", 32'(eng_start), 0);
        end else begin
            result = modExp(base, mKey, mMod);
            checkOutput("launch_eng_start", 32'(eng_start), 1);
            checkOutput("launch_eng_base", 32'(eng_base), base);
            checkOutput("launch_eng_key", 32'(eng_key), mKey);
            checkOutput("launch_eng_n", 32'(eng_n), mMod);
            checkOutput("launch_out_valid", 32'(out_valid), 0);
            if (doneInLaunch) begin
                eng_done   = 1'b1;
                eng_result = N'(~result);
            end
            timedOut = (doneDelay == 0) || (doneDelay > TMO);
            waitLen  = timedOut ? TMO : doneDelay;
            expData  = timedOut ? 0 : result;
            expErr   = timedOut ? 1 : 0;
            for (int w = 1; w <= waitLen; w++) begin
                @(negedge clk);
                checkOutput("wait_eng_start", 32'(eng_start), 0);
                checkOutput("wait_out_valid", 32'(out_valid), 0);
                checkOutput("wait_busy", 32'(busy), 1);
                checkOutput("wait_eng_key", 32'(eng_key), mKey);
                checkOutput("wait_eng_n", 32'(eng_n), mMod);
                checkOutput("wait_eng_base", 32'(eng_base), base);
                eng_done = 1'b0;
                key_load = 1'b0;
                if (w == 1 && keyLoadInWait) begin
                    key_load = 1'b1;
                    key_in   = N'(~mKey);
                    mod_in   = N'(~mMod);
                end
                if (w == doneDelay) begin
                    eng_done   = 1'b1;
                    eng_result = N'(result);
                end
            end
            @(negedge clk);
            eng_done   = 1'b0;
            key_load   = 1'b0;
            eng_result = N'($urandom);
        end
        for (int r = 0; r <= readyDelay; r++) begin
            checkOutput("hold_out_valid", 32'(out_valid), 1);
            checkOutput("hold_out_data", 32'(out_data), expData);
            checkOutput("hold_out_err", 32'(out_err), expErr);
            checkOutput("hold_in_ready", 32'(in_ready), 0);
            checkOutput("hold_eng_start", 32'(eng_start), 0);
            out_ready = (r == readyDelay);
            // A late engine answer after expiry must not disturb the held error.
            if (r == 0 && timedOut && doneDelay != 0) begin
                eng_done   = 1'b1;
                eng_result = N'(modExp(base, mKey, mMod));
            end
            @(negedge clk);
            eng_done = 1'b0;
        end
        out_ready = 1'b0;
        checkOutput("after_out_valid", 32'(out_valid), 0);
        checkOutput("after_busy", 32'(busy), 0);
        checkOutput("start_pulses", startCount - startsBefore, bad ? 0 : 1);
    endtask

    // Reset asserted mid-WAIT abandons the transaction entirely.
    task automatic resetDuringWait();
        loadKey(5, 35);
        in_valid = 1'b1;
        in_data  = N'(3);
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("rw_eng_start", 32'(eng_start), 1);
        for (int w = 0; w < 3; w++) @(negedge clk);
        checkOutput("rw_busy_wait", 32'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        checkAllZero("rw_reset");
        rst_n      = 1'b1;
        eng_done   = 1'b1;
        eng_result = N'(33);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checkOutput("rw_out_valid", 32'(out_valid), 0);
            checkOutput("rw_busy", 32'(busy), 0);
            checkOutput("rw_in_ready", 32'(in_ready), 0);
        end
        eng_done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] aborted");
    end

    initial begin
        int k;
        int m;
        int b;
        rst_n      = 1'b0;
        key_load   = 1'b0;
        key_in     = '0;
        mod_in     = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        eng_result = '0;
        eng_done   = 1'b0;
        out_ready  = 1'b0;
        mKey       = 0;
        mMod       = 0;

        applyReset();
        in_valid = 1'b1;
        @(negedge clk);
        checkOutput("nokey_busy", 32'(busy), 0);
        checkOutput("nokey_in_ready", 32'(in_ready), 0);
        in_valid = 1'b0;

        loadKey(5, 35);
        applyStimulus(3, 10, 0, 1'b0, 1'b0);
        checkOutput("first_result_is_33", modExp(3, 5, 35), 33);
        loadKey(6, 35);
        applyStimulus(50, 10, 0, 1'b0, 1'b0);
        loadKey(5, 1);
        applyStimulus(0, 5, 1, 1'b0, 1'b0);
        applyStimulus(7, 5, 0, 1'b0, 1'b0);
        loadKey(5, 35);
        applyStimulus(4, 0, 0, 1'b0, 1'b0);
        applyStimulus(2, TMO, 0, 1'b0, 1'b0);
        applyStimulus(3, TMO + 1, 0, 1'b0, 1'b0);
        applyStimulus(9, 7, 5, 1'b1, 1'b1);
        applyStimulus(11, 1, 0, 1'b0, 1'b0);
        applyStimulus(34, 3, 2, 1'b0, 1'b0);
        applyStimulus(35, 3, 0, 1'b0, 1'b0);

        resetDuringWait();

        for (int t = 0; t < 40; t++) begin
            if (t == 0 || $urandom_range(0, 9) < 3) begin
                k = $urandom_range(0, 63);
                m = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2) : $urandom_range(2, 63);
                loadKey(k, m);
            end
            if (mMod > 0 && $urandom_range(0, 3) != 0) b = $urandom_range(0, mMod - 1);
            else b = $urandom_range(0, 63);
            applyStimulus(b, $urandom_range(0, TMO + 4), $urandom_range(0, 3),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
